// File: rtl/debounce_pkg.sv
// Shared types and helpers for the time-shared button debouncer.
// No datapath, no latency, no backpressure.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_SCAN   = 2'd0,
    S_COUNT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam int NDELAY_SIM = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/debounce_sched_sync2.sv
// Single-bit two-flop synchronizer, cleared to 0 on reset.
// Latency 2 cycles; no backpressure.
module sync2 (
  input  logic clk_in,
  input  logic RST_in,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or posedge RST_in) begin
    if (RST_in) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_sched.sv
// One debounce timer shared round-robin across NBTN buttons; commit lands NDELAY+2
// edges after a stable input change when idle. No backpressure: outputs are pulses.
module debounce_sched
  import debounce_pkg::*;
#(
  parameter int NBTN   = 4,
  parameter int NDELAY = 25000000,
  parameter int NBITS  = 26,
  parameter int IDXW   = 2
) (
  input  logic            clk_in,
  input  logic            RST_in,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] btn_state_out,
  output logic [NBTN-1:0] press_pulse_out,
  output logic [NBTN-1:0] release_pulse_out,
  output logic            busy_out,
  output logic [IDXW-1:0] active_idx_out
);

  logic [NBTN-1:0]  sync;
  logic [NBTN-1:0]  mism;
  state_t           state, state_nxt;
  logic [IDXW-1:0]  ptr, ptr_nxt, idx_nxt, sel_c, ptr_inc;
  logic [NBITS-1:0] count, count_nxt;
  logic             target, target_nxt, found;
  logic [NBTN-1:0]  st_nxt, press_nxt, release_nxt;

  for (genvar i = 0; i < NBTN; i++) begin : g_sync
    sync2 u_sync (
      .clk_in (clk_in),
      .RST_in (RST_in),
      .d      (btn_in[i]),
      .q      (sync[i])
    );
  end

  assign mism     = sync ^ btn_state_out;
  assign busy_out = (state != S_SCAN);
  assign ptr_inc  = (active_idx_out == IDXW'(NBTN - 1)) ? '0 : active_idx_out + 1'b1;

  // First mismatching button at or after ptr, wrapping.
  always_comb begin
    int j;
    found = 1'b0;
    sel_c = '0;
    for (int k = 0; k < NBTN; k++) begin
      j = int'(ptr) + k;
      if (j >= NBTN) j = j - NBTN;
      if (!found && mism[j]) begin
        found = 1'b1;
        sel_c = IDXW'(j);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = active_idx_out;
    count_nxt   = count;
    target_nxt  = target;
    st_nxt      = btn_state_out;
    press_nxt   = '0;
    release_nxt = '0;
    case (state)
      S_SCAN: begin
        if (found) begin
          target_nxt = sync[sel_c];
          idx_nxt    = sel_c;
          count_nxt  = '0;
          state_nxt  = S_COUNT;
        end
      end
      S_COUNT: begin
        if (sync[active_idx_out] != target) begin
          ptr_nxt   = ptr_inc;
          state_nxt = S_SCAN;
        end else if (count == NBITS'(NDELAY - 1)) begin
          st_nxt[active_idx_out] = target;
          if (target) press_nxt[active_idx_out] = 1'b1;
          else        release_nxt[active_idx_out] = 1'b1;
          state_nxt = S_COMMIT;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      S_COMMIT: begin
        ptr_nxt   = ptr_inc;
        state_nxt = S_SCAN;
      end
      default: state_nxt = S_SCAN;
    endcase
  end

  always_ff @(posedge clk_in or posedge RST_in) begin
    if (RST_in) begin
      state             <= S_SCAN;
      ptr               <= '0;
      active_idx_out    <= '0;
      count             <= '0;
      target            <= 1'b0;
      btn_state_out     <= '0;
      press_pulse_out   <= '0;
      release_pulse_out <= '0;
    end else begin
      state             <= state_nxt;
      ptr               <= ptr_nxt;
      active_idx_out    <= idx_nxt;
      count             <= count_nxt;
      target            <= target_nxt;
      btn_state_out     <= st_nxt;
      press_pulse_out   <= press_nxt;
      release_pulse_out <= release_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_sched.sv
// Directed bench for debounce_sched with NDELAY=8, NBTN=4.
module tb_debounce_sched;
  import debounce_pkg::*;

  logic       clk_in;
  logic       RST_in;
  logic [3:0] btn_in;
  logic [3:0] btn_state_out, press_pulse_out, release_pulse_out;
  logic       busy_out;
  logic [1:0] active_idx_out;

  int errors = 0;
  int checks = 0;

  debounce_sched #(
    .NBTN   (4),
    .NDELAY (NDELAY_SIM),
    .NBITS  (4),
    .IDXW   (2)
  ) dut (
    .clk_in            (clk_in),
    .RST_in            (RST_in),
    .btn_in            (btn_in),
    .btn_state_out     (btn_state_out),
    .press_pulse_out   (press_pulse_out),
    .release_pulse_out (release_pulse_out),
    .busy_out          (busy_out),
    .active_idx_out    (active_idx_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] all_out();
    return {btn_state_out, press_pulse_out, release_pulse_out, busy_out, 1'b0, active_idx_out};
  endfunction

  initial begin
    int first;
    logic [1:0] lowpulse;

    // Reset and idle
    RST_in = 1'b1;
    btn_in = 4'b0000;
    #1;
    chk("reset_outputs", all_out(), 16'h0000);
    step(2);
    RST_in = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step(1);
      if (c % 10 == 9) chk("idle_outputs", all_out(), 16'h0000);
    end

    // Press and release of bit 2
    btn_in = 4'b0100;
    step(2);
    chk("p2_busy_e1", {15'd0, busy_out}, 16'd0);
    step(1);
    chk("p2_grant", {13'd0, busy_out, active_idx_out}, {13'd0, 1'b1, 2'd2});
    step(7);
    chk("p2_press_e9", {12'd0, press_pulse_out}, 16'h0000);
    step(1);
    chk("p2_press_e10", {press_pulse_out, release_pulse_out, btn_state_out, 3'd0, busy_out},
        {4'b0100, 4'b0000, 4'b0100, 3'd0, 1'b1});
    step(1);
    chk("p2_after", {press_pulse_out, btn_state_out, 5'd0, busy_out, active_idx_out},
        {4'b0000, 4'b0100, 5'd0, 1'b0, 2'd2});
    btn_in = 4'b0000;
    step(10);
    chk("r2_e9", {12'd0, release_pulse_out}, 16'h0000);
    step(1);
    chk("r2_e10", {press_pulse_out, release_pulse_out, btn_state_out, 4'd0},
        {4'b0000, 4'b0100, 4'b0000, 4'd0});
    step(1);
    chk("r2_after", {12'd0, release_pulse_out}, 16'h0000);
    step(5);

    // Short pulse on bit 1 aborts
    btn_in = 4'b0010;
    step(5);
    chk("ab1_counting", {13'd0, busy_out, active_idx_out}, {13'd0, 1'b1, 2'd1});
    btn_in = 4'b0000;
    step(2);
    chk("ab1_still_busy", {15'd0, busy_out}, 16'd1);
    step(1);
    chk("ab1_aborted", {15'd0, busy_out}, 16'd0);
    lowpulse = 2'b00;
    first = 0;
    for (int c = 0; c < 15; c++) begin
      step(1);
      if (press_pulse_out != 4'b0000 || release_pulse_out != 4'b0000 || btn_state_out != 4'b0000)
        first++;
    end
    chk("ab1_no_output", 16'(first), 16'd0);

    // ptr is now 2: bits 0 and 3 together -> bit 3 first
    btn_in = 4'b1001;
    step(3);
    chk("ptr2_grant3", {13'd0, busy_out, active_idx_out}, {13'd0, 1'b1, 2'd3});
    step(8);
    chk("ptr2_press3", {12'd0, press_pulse_out}, 16'h0008);
    step(2);
    chk("ptr2_grant0", {13'd0, busy_out, active_idx_out}, {13'd0, 1'b1, 2'd0});
    step(8);
    chk("ptr2_press0", {press_pulse_out, btn_state_out, 8'd0}, {4'b0001, 4'b1001, 8'd0});
    step(2);
    btn_in = 4'b0000;
    step(30);
    chk("ptr2_released", {12'd0, btn_state_out}, 16'h0000);

    // Reset, then simultaneous rise with ptr=0 -> bit 0 first
    RST_in = 1'b1;
    step(2);
    RST_in = 1'b0;
    step(3);
    btn_in = 4'b1001;
    step(3);
    chk("sim_grant0", {13'd0, busy_out, active_idx_out}, {13'd0, 1'b1, 2'd0});
    step(8);
    chk("sim_press0", {press_pulse_out, release_pulse_out, 8'd0}, {4'b0001, 4'b0000, 8'd0});
    step(2);
    chk("sim_grant3", {13'd0, busy_out, active_idx_out}, {13'd0, 1'b1, 2'd3});
    step(7);
    chk("sim_press3_early", {12'd0, press_pulse_out}, 16'h0000);
    step(1);
    chk("sim_press3", {press_pulse_out, btn_state_out, 8'd0}, {4'b1000, 4'b1001, 8'd0});
    step(1);
    chk("sim_press3_drop", {12'd0, press_pulse_out}, 16'h0000);
    btn_in = 4'b0000;
    step(25);
    chk("sim_released", {12'd0, btn_state_out}, 16'h0000);

    // Bits 0,1 toggle every 4 cycles while bit 2 is held
    btn_in = 4'b0111;
    first = 0;
    lowpulse = 2'b00;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (press_pulse_out == 4'b0100 && first == 0) first = c;
      lowpulse = lowpulse | press_pulse_out[1:0] | release_pulse_out[1:0];
      if (c % 4 == 0) btn_in[1:0] = ~btn_in[1:0];
    end
    chk("rr_bit2_press_cycle", 16'(first), 16'd16);
    chk("rr_no_low_pulse", {14'd0, lowpulse}, 16'd0);
    chk("rr_state", {12'd0, btn_state_out}, 16'h0004);

    // Reset mid-count, then recovery with button held
    btn_in = 4'b0000;
    RST_in = 1'b1;
    step(2);
    RST_in = 1'b0;
    step(3);
    btn_in = 4'b0001;
    step(8);
    chk("rst_midcount_busy", {13'd0, busy_out, active_idx_out}, {13'd0, 1'b1, 2'd0});
    RST_in = 1'b1;
    #1;
    chk("rst_immediate", all_out(), 16'h0000);
    step(3);
    chk("rst_held", all_out(), 16'h0000);
    RST_in = 1'b0;
    step(10);
    chk("rst_recover_early", {12'd0, press_pulse_out}, 16'h0000);
    step(1);
    chk("rst_recover_press", {press_pulse_out, btn_state_out, 8'd0}, {4'b0001, 4'b0001, 8'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_sched.md
Name: debounce_sched

Overview:
- Shares one debounce timer among NBTN raw push-button inputs instead of one counter per button.
- Synchronizes each input, grants the timer round-robin to a button whose synced level differs from its committed state, and commits the new level once it has held stable for NDELAY cycles.
- Emits one-cycle press/release pulses and the committed levels.
- Sits between the board buttons and the lab control logic.

Parameters:
- NBTN, 4, number of button inputs (2..16).
- NDELAY, 25000000, stable cycles required before commit (>=2).
- NBITS, 26, counter width; must hold NDELAY-1.
- IDXW, 2, index width, equal to clog2(NBTN).

Ports:
- clk_in  input  1  system clock.
- RST_in  input  1  reset, asynchronous, active-high.
- btn_in  input  NBTN  raw asynchronous button levels.
- btn_state_out  output  NBTN  committed debounced levels.
- press_pulse_out  output  NBTN  one-cycle pulse on a committed 0->1.
- release_pulse_out  output  NBTN  one-cycle pulse on a committed 1->0.
- busy_out  output  1  high while the timer is granted (COUNT or COMMIT).
- active_idx_out  output  IDXW  index of the granted button; holds the last grant otherwise.

Behaviour:
- Decided: reset RST_in, asynchronous, active-high; clock clk_in. Every register clears on RST_in.
- Reset values: sync stages 0, btn_state_out 0, pulses 0, busy_out 0, active_idx_out 0, ptr 0, count 0, FSM=SCAN.
- Synchronizer: 2-flop per bit, giving sync[i]. Mismatch is defined as mism[i] = sync[i] != btn_state_out[i].
- SCAN, when any mism is set:
  - sel = first mismatching index searching ptr, ptr+1, ... wrapping mod NBTN.
  - Latch target = sync[sel], set active_idx_out = sel, count = 0, go to COUNT. busy_out goes high the same edge.
- SCAN, when no mism is set: stay in SCAN; ptr unchanged.
- COUNT, priority order:
  - (a) If sync[sel] != target: abort. No state change, no pulse, ptr = sel+1 mod NBTN, go to SCAN.
  - (b) Else if count == NDELAY-1: at this edge btn_state_out[sel] = target and the matching pulse bit is set; go to COMMIT.
  - (c) Else count = count+1.
- COMMIT: lasts exactly 1 cycle with the pulse high. At the next edge the pulse clears, ptr = sel+1 mod NBTN, go to SCAN, busy_out goes low.
- Latency: btn_in changes before edge E0 and stays stable with the FSM idle. The pulse and btn_state_out update are visible after edge E0+NDELAY+2; the pulse drops after E0+NDELAY+3.
- Other buttons changing during COUNT are not observed until SCAN; they are serviced later, never lost while still held.
- Fairness: after any grant ends, the granted index becomes lowest priority.
- A glitch shorter than the window aborts with no output. A level that returns to its committed value before SCAN is ignored.
- Only one pulse bit is asserted in any cycle; press and release are never both high.
- Reset mid-COUNT or mid-COMMIT: immediate clear, no pulse completes.
- Count never exceeds NDELAY-1; there is no wrap-around.

Decomposition:
- Package debounce_pkg holds:
  - FSM encodings S_SCAN=2'd0, S_COUNT=2'd1, S_COMMIT=2'd2;
  - a clog2 function for IDXW;
  - a TB default NDELAY_SIM=8.
- Sub-module sync2 is a single-bit 2-flop synchronizer with reset to 0, instanced NBTN times.
- The round-robin find-first is combinational logic inside debounce_sched.

Test Plan (NDELAY=8, NBTN=4):
- Reset then btn_in=4'b0000 held 50 cycles -> outputs stay 0, busy_out 0, active_idx_out 0.
- btn_in[2] 0->1 before E0, held -> press_pulse_out=4'b0100 for exactly the cycle after E0+10, btn_state_out=4'b0100 afterward. Then drop it -> release_pulse_out=4'b0100 with the same latency.
- btn_in[1] high 5 cycles then low -> COUNT entered then aborted, no pulse, btn_state_out unchanged, ptr becomes 2.
- btn_in[0] and btn_in[3] rise in the same cycle with ptr=0 -> press on bit 0 first. Bit 3 is granted on the following SCAN; its pulse lands 1+NDELAY+1 cycles after bit 0's COMMIT.
- bits 0 and 1 continuously toggling every 4 cycles, bit 2 rising and held -> bit 2 still committed within 3 aborted grants (round-robin, no starvation).
- RST_in asserted at count=5 during a press -> all outputs 0 immediately. After release of RST_in with btn held, the press pulse arrives NDELAY+2 edges later.
